// File: rtl/writeback_arbiter.sv
// Multi-channel writeback stage: two independent round-robin arbiters
// (integer file and float file) pick at most one result each per cycle
// from NCH execution channels and register the chosen write for the
// register files, along with a per-channel completion pulse.
module writeback_arbiter #(
  parameter int NCH  = 3,
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enabled,
  input  logic [NCH-1:0]      ch_valid,
  output logic [NCH-1:0]      ch_ready,
  input  logic [NCH-1:0]      ch_to_freg,
  input  logic [NCH*RAW-1:0]  ch_rd,
  input  logic [NCH*XLEN-1:0] ch_data,
  output logic                reg_w_enable,
  output logic [RAW-1:0]      reg_w_dest,
  output logic [XLEN-1:0]     reg_w_data,
  output logic                freg_w_enable,
  output logic [RAW-1:0]      freg_w_dest,
  output logic [XLEN-1:0]     freg_w_data,
  output logic [NCH-1:0]      completed
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]   int_ptr;
  logic [PW-1:0]   fp_ptr;
  logic [NCH-1:0]  req_int;
  logic [NCH-1:0]  req_fp;
  logic [NCH-1:0]  grant_int;
  logic [NCH-1:0]  grant_fp;
  logic [PW-1:0]   int_idx;
  logic [PW-1:0]   fp_idx;
  logic [RAW-1:0]  int_rd;
  logic [XLEN-1:0] int_data;
  logic [RAW-1:0]  fp_rd;
  logic [XLEN-1:0] fp_data;

  // First requester at or after the pointer wins; if none, the search wraps
  // to the channels below the pointer. Two passes avoid any modulo counter.
  function automatic logic [NCH-1:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [PW-1:0]  ptr);
    logic [NCH-1:0] g;
    logic           found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Index of the single set bit of a grant vector (zero when empty).
  function automatic logic [PW-1:0] onehot_idx(input logic [NCH-1:0] g);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  // Pointer advance past the winner; NCH need not be a power of two, so the
  // wrap is an explicit compare against the last channel.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(NCH - 1)) ? '0 : idx + PW'(1);
  endfunction

  // Split requests by destination file and arbitrate each file independently.
  always_comb begin
    req_int   = ch_valid & ~ch_to_freg;
    req_fp    = ch_valid & ch_to_freg;
    grant_int = '0;
    grant_fp  = '0;
    if (enabled) begin
      grant_int = rr_pick(req_int, int_ptr);
      grant_fp  = rr_pick(req_fp, fp_ptr);
    end
  end

  assign ch_ready = grant_int | grant_fp;
  assign int_idx  = onehot_idx(grant_int);
  assign fp_idx   = onehot_idx(grant_fp);

  // Select destination and data of the granted channel for each file.
  always_comb begin
    int_rd   = '0;
    int_data = '0;
    fp_rd    = '0;
    fp_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_int[i]) begin
        int_rd   = ch_rd[i*RAW +: RAW];
        int_data = ch_data[i*XLEN +: XLEN];
      end
      if (grant_fp[i]) begin
        fp_rd   = ch_rd[i*RAW +: RAW];
        fp_data = ch_data[i*XLEN +: XLEN];
      end
    end
  end

  // Round-robin pointers move only when their arbiter actually grants.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_ptr <= '0;
      fp_ptr  <= '0;
    end else begin
      if (|grant_int) int_ptr <= next_ptr(int_idx);
      if (|grant_fp)  fp_ptr  <= next_ptr(fp_idx);
    end
  end

  // Integer write port; writes to x0 retire without raising the strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_w_enable <= 1'b0;
      reg_w_dest   <= '0;
      reg_w_data   <= '0;
    end else begin
      reg_w_enable <= (|grant_int) && (int_rd != '0);
      if (|grant_int) begin
        reg_w_dest <= int_rd;
        reg_w_data <= int_data;
      end
    end
  end

  // Float write port; f0 is an ordinary register, so every grant writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      freg_w_enable <= 1'b0;
      freg_w_dest   <= '0;
      freg_w_data   <= '0;
    end else begin
      freg_w_enable <= |grant_fp;
      if (|grant_fp) begin
        freg_w_dest <= fp_rd;
        freg_w_data <= fp_data;
      end
    end
  end

  // Completion pulse for every channel whose result was accepted last cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      completed <= '0;
    end else begin
      completed <= grant_int | grant_fp;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that
// arbitrates with modulo arithmetic over per-channel result records.
module tb_writeback_arbiter;

  localparam int NCH  = 3;
  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic                clk = 1'b0;
  logic                rstn;
  logic                enabled;
  logic [NCH-1:0]      ch_valid;
  logic [NCH-1:0]      ch_ready;
  logic [NCH-1:0]      ch_to_freg;
  logic [NCH*RAW-1:0]  ch_rd;
  logic [NCH*XLEN-1:0] ch_data;
  logic                reg_w_enable;
  logic [RAW-1:0]      reg_w_dest;
  logic [XLEN-1:0]     reg_w_data;
  logic                freg_w_enable;
  logic [RAW-1:0]      freg_w_dest;
  logic [XLEN-1:0]     freg_w_data;
  logic [NCH-1:0]      completed;

  // Pending result held by each channel
  logic            vValid [NCH];
  logic            vFreg  [NCH];
  logic [RAW-1:0]  vRd    [NCH];
  logic [XLEN-1:0] vData  [NCH];

  // Reference model state
  int              ptrInt;
  int              ptrFp;
  int              lastGI;
  int              lastGF;
  logic            expRegEn;
  logic            expFEn;
  logic [RAW-1:0]  expRegDest;
  logic [RAW-1:0]  expFDest;
  logic [XLEN-1:0] expRegData;
  logic [XLEN-1:0] expFData;
  logic [NCH-1:0]  expCompleted;
  bit              regXfer;
  bit              fXfer;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter #(.NCH(NCH), .XLEN(XLEN), .RAW(RAW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enabled      (enabled),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_to_freg   (ch_to_freg),
    .ch_rd        (ch_rd),
    .ch_data      (ch_data),
    .reg_w_enable (reg_w_enable),
    .reg_w_dest   (reg_w_dest),
    .reg_w_data   (reg_w_data),
    .freg_w_enable(freg_w_enable),
    .freg_w_dest  (freg_w_dest),
    .freg_w_data  (freg_w_data),
    .completed    (completed)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Model arbiter: scan channels ptr, ptr+1, ... modulo NCH
  function automatic int pick(input logic [NCH-1:0] req, input int ptr);
    int c;
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) begin
      c = (ptr + k) % NCH;
      r = req >> c;
      if (r[0]) return c;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i]               = vValid[i];
      ch_to_freg[i]             = vFreg[i];
      ch_rd[i*RAW +: RAW]       = vRd[i];
      ch_data[i*XLEN +: XLEN]   = vData[i];
    end
  endtask

  task automatic setCh(input int i, input logic v, input logic f,
                       input logic [RAW-1:0] rd, input logic [XLEN-1:0] d);
    vValid[i] = v;
    vFreg[i]  = f;
    vRd[i]    = rd;
    vData[i]  = d;
  endtask

  task automatic clearAll();
    for (int i = 0; i < NCH; i++) setCh(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic resetModel();
    ptrInt       = 0;
    ptrFp        = 0;
    lastGI       = -1;
    lastGF       = -1;
    expRegEn     = 1'b0;
    expFEn       = 1'b0;
    expCompleted = '0;
    regXfer      = 1'b0;
    fXfer        = 1'b0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_reg_w_enable",  reg_w_enable,  1'b0);
    checkOutput("rst_reg_w_dest",    reg_w_dest,    '0);
    checkOutput("rst_reg_w_data",    reg_w_data,    '0);
    checkOutput("rst_freg_w_enable", freg_w_enable, 1'b0);
    checkOutput("rst_freg_w_dest",   freg_w_dest,   '0);
    checkOutput("rst_freg_w_data",   freg_w_data,   '0);
    checkOutput("rst_completed",     completed,     '0);
  endtask

  // One clock cycle: drive at the falling edge, check ready, let the rising
  // edge happen, then check the registered outputs at the next falling edge.
  task automatic runCycle();
    logic [NCH-1:0] reqI;
    logic [NCH-1:0] reqF;
    logic [NCH-1:0] expReady;
    int gI;
    int gF;
    applyStimulus();
    #1;
    reqI = '0;
    reqF = '0;
    for (int i = 0; i < NCH; i++) begin
      if (vValid[i] && !vFreg[i]) reqI = reqI | (NCH'(1) << i);
      if (vValid[i] &&  vFreg[i]) reqF = reqF | (NCH'(1) << i);
    end
    gI = enabled ? pick(reqI, ptrInt) : -1;
    gF = enabled ? pick(reqF, ptrFp)  : -1;
    expReady = '0;
    if (gI >= 0) expReady = expReady | (NCH'(1) << gI);
    if (gF >= 0) expReady = expReady | (NCH'(1) << gF);
    checkOutput("ch_ready", ch_ready, expReady);
    @(posedge clk);
    expCompleted = '0;
    regXfer      = (gI >= 0);
    fXfer        = (gF >= 0);
    expRegEn     = 1'b0;
    expFEn       = 1'b0;
    if (gI >= 0) begin
      expRegEn     = (vRd[gI] != '0);
      expRegDest   = vRd[gI];
      expRegData   = vData[gI];
      expCompleted = expCompleted | (NCH'(1) << gI);
      ptrInt       = (gI + 1) % NCH;
    end
    if (gF >= 0) begin
      expFEn       = 1'b1;
      expFDest     = vRd[gF];
      expFData     = vData[gF];
      expCompleted = expCompleted | (NCH'(1) << gF);
      ptrFp        = (gF + 1) % NCH;
    end
    lastGI = gI;
    lastGF = gF;
    @(negedge clk);
    checkOutput("reg_w_enable",  reg_w_enable,  expRegEn);
    checkOutput("freg_w_enable", freg_w_enable, expFEn);
    checkOutput("completed",     completed,     expCompleted);
    if (regXfer) begin
      checkOutput("reg_w_dest", reg_w_dest, expRegDest);
      checkOutput("reg_w_data", reg_w_data, expRegData);
    end
    if (fXfer) begin
      checkOutput("freg_w_dest", freg_w_dest, expFDest);
      checkOutput("freg_w_data", freg_w_data, expFData);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    resetModel();
  endtask

  task automatic newResult(input int i);
    vValid[i] = 1'b1;
    vFreg[i]  = $urandom_range(1, 0) == 1;
    vRd[i]    = ($urandom_range(5, 0) == 0) ? '0 : RAW'($urandom);
    vData[i]  = $urandom;
  endtask

  // Main sequence
  initial begin
    rstn    = 1'b0;
    enabled = 1'b0;
    clearAll();
    applyStimulus();
    resetModel();
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rstn = 1'b1;

    // Single integer write after reset
    enabled = 1'b1;
    setCh(0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    runCycle();
    checkOutput("t1_reg_w_enable",  reg_w_enable,  1'b1);
    checkOutput("t1_reg_w_dest",    reg_w_dest,    5'd5);
    checkOutput("t1_reg_w_data",    reg_w_data,    32'hDEADBEEF);
    checkOutput("t1_freg_w_enable", freg_w_enable, 1'b0);
    checkOutput("t1_completed",     completed,     3'b001);
    clearAll();
    runCycle();

    // Round-robin fairness with all channels requesting the integer file
    resetDut();
    setCh(0, 1'b1, 1'b0, 5'd1, 32'h100);
    setCh(1, 1'b1, 1'b0, 5'd2, 32'h200);
    setCh(2, 1'b1, 1'b0, 5'd3, 32'h300);
    for (int k = 0; k < 6; k++) begin
      runCycle();
      checkOutput("rr_completed", completed,  NCH'(1) << (k % 3));
      checkOutput("rr_dest",      reg_w_dest, RAW'(k % 3 + 1));
    end
    clearAll();

    // Integer and float writes accepted in the same cycle
    setCh(1, 1'b1, 1'b0, 5'd7, 32'h11);
    setCh(2, 1'b1, 1'b1, 5'd0, 32'h3F800000);
    runCycle();
    checkOutput("dual_completed",   completed,     3'b110);
    checkOutput("dual_reg_dest",    reg_w_dest,    5'd7);
    checkOutput("dual_reg_data",    reg_w_data,    32'h11);
    checkOutput("dual_freg_enable", freg_w_enable, 1'b1);
    checkOutput("dual_freg_dest",   freg_w_dest,   5'd0);
    checkOutput("dual_freg_data",   freg_w_data,   32'h3F800000);
    clearAll();

    // Write to x0 retires without a strobe
    setCh(0, 1'b1, 1'b0, 5'd0, 32'h1234);
    runCycle();
    checkOutput("x0_reg_w_enable", reg_w_enable, 1'b0);
    checkOutput("x0_completed",    completed,    3'b001);
    clearAll();

    // Global enable gating
    enabled = 1'b0;
    setCh(0, 1'b1, 1'b0, 5'd9, 32'hCAFE0009);
    for (int k = 0; k < 3; k++) begin
      runCycle();
      checkOutput("gate_reg_w_enable", reg_w_enable, 1'b0);
      checkOutput("gate_completed",    completed,    '0);
    end
    enabled = 1'b1;
    runCycle();
    checkOutput("gate_release_enable",    reg_w_enable, 1'b1);
    checkOutput("gate_release_completed", completed,    3'b001);
    clearAll();
    runCycle();
    checkOutput("gate_no_duplicate", completed, '0);

    // Asynchronous reset in the middle of a stream
    setCh(0, 1'b1, 1'b0, 5'd3, 32'hAAAA0003);
    setCh(1, 1'b1, 1'b0, 5'd4, 32'hBBBB0004);
    runCycle();
    runCycle();
    #2;
    rstn = 1'b0;
    #1;
    checkResetOutputs();
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("post_rst_reg_w_enable", reg_w_enable, 1'b0);
    checkOutput("post_rst_completed",    completed,    '0);
    runCycle();
    checkOutput("post_rst_first_grant", completed, 3'b001);
    clearAll();
    runCycle();

    // Randomized traffic obeying the hold-until-ready protocol
    for (int n = 0; n < 400; n++) begin
      enabled = ($urandom_range(7, 0) != 0);
      for (int i = 0; i < NCH; i++) begin
        if (!vValid[i] && ($urandom_range(2, 0) != 0)) newResult(i);
      end
      runCycle();
      if (lastGI >= 0) vValid[lastGI] = 1'b0;
      if (lastGF >= 0) vValid[lastGF] = 1'b0;
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Multi-channel writeback stage of the core.
- Accepts results from NCH execution channels (e.g. ALU, FPU, load unit) and arbitrates them onto one integer register-file write port and one float register-file write port per cycle.
- Reports per-channel completion.
- Successor to the single-channel write stage; adds channel count, valid/ready handshake, round-robin fairness and x0 suppression.

Parameters:
- NCH, 3, number of result channels (2..8).
- XLEN, 32, data width.
- RAW, 5, register address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enabled  in  1  global writeback enable; when low, no grants are issued
- ch_valid  in  NCH  channel i presents a result
- ch_ready  out  NCH  channel i result accepted this cycle (combinational)
- ch_to_freg  in  NCH  1 = destination is the float file, 0 = integer file
- ch_rd  in  NCH*RAW  destination register, channel i at bits [i*RAW +: RAW]
- ch_data  in  NCH*XLEN  result data, channel i at bits [i*XLEN +: XLEN]
- reg_w_enable  out  1  integer file write strobe (registered)
- reg_w_dest  out  RAW  integer write address
- reg_w_data  out  XLEN  integer write data
- freg_w_enable  out  1  float file write strobe (registered)
- freg_w_dest  out  RAW  float write address
- freg_w_data  out  XLEN  float write data
- completed  out  NCH  one-cycle pulse per channel whose result retired (registered)

Behaviour:
- Reset (rstn low, async):
  - reg_w_enable = freg_w_enable = 0
  - reg_w_dest, freg_w_dest, reg_w_data, freg_w_data = 0
  - completed = 0
  - both round-robin pointers = 0
  - Any in-flight acceptance is dropped; on release, arbitration starts from channel 0.
- Two independent arbiters, INT and FP.
  - Requesters: INT = ch_valid & ~ch_to_freg; FP = ch_valid & ch_to_freg.
  - Each grants at most one channel per cycle, round-robin: search begins at its pointer, wraps modulo NCH.
  - The first requesting channel at or after the pointer wins.
  - On a grant to channel g, the pointer becomes (g+1) mod NCH at the clock edge.
  - Without a grant, the pointer holds.
- ch_ready[i] = enabled & grant_int[i] | enabled & grant_fp[i]. Purely combinational from ch_valid, ch_to_freg, pointer and enabled.
- A transfer occurs when ch_valid[i] & ch_ready[i].
  - The channel holds valid, rd, data and to_freg stable until ready.
  - A channel may present a new result in the very next cycle.
- Latency: write strobes and completed assert exactly 1 cycle after the transfer cycle.
- INT transfer from channel g, next cycle:
  - reg_w_dest = rd_g, reg_w_data = data_g.
  - reg_w_enable = 1 unless rd_g == 0. x0 writes are suppressed but still complete.
- FP transfer: same, on the freg_* ports. f0 is a normal register with no suppression.
- completed[g] = 1 for each channel transferred in the previous cycle. Up to two bits may be set at once: one INT, one FP.
- Without a transfer on a file, its w_enable is 0 the next cycle. dest/data hold their last value and are don't-care.
- enabled low:
  - ch_ready = 0 and pointers hold.
  - Strobes and completed go to 0 on the following edge.
  - Results already registered still appear in that edge's cycle; no write is lost or duplicated.
- Simultaneous INT and FP from different channels: both accepted the same cycle, each on its own port.
- A single channel never receives two grants in one cycle, because to_freg is exclusive.
- NCH not a power of two: wrap-around uses an explicit compare, never a truncated counter.

Test Plan:
- Reset then single INT write:
  - Stimulus: ch0 valid, rd=5, data=0xDEADBEEF, enabled=1.
  - Response: ch_ready[0]=1 same cycle; next cycle reg_w_enable=1, reg_w_dest=5, reg_w_data=0xDEADBEEF, completed=3'b001; freg_w_enable=0.
- Round-robin fairness:
  - Stimulus: all 3 channels request INT continuously, rd=1/2/3.
  - Response: grant order 0,1,2,0,1,2 over 6 cycles; completed one-hot rotates 001,010,100,…
- Dual-port:
  - Stimulus: ch1 INT rd=7 data=0x11, ch2 FP rd=0 data=0x3F800000, same cycle.
  - Response: both ready; next cycle reg write (7,0x11) and freg write (0,0x3F800000); completed=3'b110.
- x0 suppression:
  - Stimulus: ch0 INT rd=0 data=0x1234.
  - Response: ready=1; next cycle reg_w_enable=0, completed[0]=1.
- enabled gating:
  - Stimulus: ch0 INT requests with enabled=0 for 3 cycles, then enabled=1.
  - Response: ready=0 and no strobes for 3 cycles; exactly one write and one completed pulse after enable.
- Async reset mid-stream:
  - Stimulus: assert rstn=0 between clock edges while ch0/ch1 stream.
  - Response: all outputs 0 immediately, no strobe after release until a new transfer; first grant after release goes to the lowest requesting channel from 0.
